// File: rtl/enytank_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// enytank_spawn_ctrl - enemy-tank respawn FSMs with capped round-robin grants;
// macro SPAWN_TIMEOUT_EN adds a spawn-ack timeout with spawn_err.   Rev 1.0
// ============================================================================
module enytank_spawn_ctrl #(
  parameter int N_TANK        = 4,
  parameter int RESPAWN_TICKS = 8,
  parameter int MAX_ALIVE     = 3,
  parameter int SPAWN_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        game_en,
  input  logic [N_TANK-1:0]           tank_state,
  output logic [N_TANK-1:0]           tank_en,
  output logic [$clog2(N_TANK+1)-1:0] alive_cnt,
  output logic                        spawn_err
);

  localparam int                 CNT_W        = $clog2(N_TANK + 1);
  localparam int                 IDX_W        = (N_TANK > 1) ? $clog2(N_TANK) : 1;
  localparam logic [7:0]         RESPAWN_LOAD = 8'(RESPAWN_TICKS);
  localparam logic [CNT_W-1:0]   MAX_ALIVE_C  = CNT_W'(MAX_ALIVE);
  localparam logic [IDX_W-1:0]   PTR_RST      = IDX_W'(N_TANK - 1);

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_READY    = 2'd1,
    ST_SPAWNING = 2'd2,
    ST_ALIVE    = 2'd3
  } chan_state_e;

  chan_state_e       state_q [N_TANK];
  chan_state_e       state_d [N_TANK];
  logic [7:0]        cnt_q   [N_TANK];
  logic [7:0]        cnt_d   [N_TANK];
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  scan_idx;
  logic [N_TANK-1:0] tank_en_q, tank_en_d;
  logic [CNT_W-1:0]  alive_cnt_q, alive_cnt_d;
  logic [N_TANK-1:0] grant;
  logic              grant_ok;

`ifdef SPAWN_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(SPAWN_TIMEOUT - 1);
  logic [7:0] to_q [N_TANK];
  logic [7:0] to_d [N_TANK];
  logic       spawn_err_q, spawn_err_d;
`endif

  // Uses the registered alive count, so a same-cycle death frees no slot yet.
  always_comb begin
    grant    = '0;
    rr_d     = rr_q;
    scan_idx = '0;
    grant_ok = tick && game_en && (alive_cnt_q < MAX_ALIVE_C);
    for (int k = 1; k <= N_TANK; k++) begin
      scan_idx = IDX_W'((int'(rr_q) + k) % N_TANK);
      if (grant_ok && (grant == '0) && (state_q[scan_idx] == ST_READY) &&
          !tank_state[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        rr_d            = scan_idx;
      end
    end
  end

  always_comb begin
    tank_en_d   = '0;
    alive_cnt_d = '0;
`ifdef SPAWN_TIMEOUT_EN
    spawn_err_d = 1'b0;
`endif
    for (int i = 0; i < N_TANK; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef SPAWN_TIMEOUT_EN
      to_d[i]    = to_q[i];
`endif
      case (state_q[i])
        ST_WAIT: begin
          if (tank_state[i]) begin
            state_d[i] = ST_ALIVE;
          end else if (tick && game_en) begin
            if (cnt_q[i] > 8'd1) begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end else begin
              state_d[i] = ST_READY;
              cnt_d[i]   = '0;
            end
          end
        end
        ST_READY: begin
          if (tank_state[i]) begin
            state_d[i] = ST_ALIVE;
          end else if (grant[i]) begin
            state_d[i] = ST_SPAWNING;
`ifdef SPAWN_TIMEOUT_EN
            to_d[i]    = '0;
`endif
          end
        end
        ST_SPAWNING: begin
          if (tank_state[i]) begin
            state_d[i] = ST_ALIVE;
          end else if (!game_en) begin
            state_d[i] = ST_READY;
          end
`ifdef SPAWN_TIMEOUT_EN
          else if (tick) begin
            if (to_q[i] >= TIMEOUT_LAST) begin
              state_d[i]  = ST_WAIT;
              cnt_d[i]    = RESPAWN_LOAD;
              spawn_err_d = 1'b1;
            end else begin
              to_d[i] = to_q[i] + 8'd1;
            end
          end
`endif
        end
        ST_ALIVE: begin
          if (!tank_state[i]) begin
            state_d[i] = ST_WAIT;
            cnt_d[i]   = RESPAWN_LOAD;
          end
        end
        default: state_d[i] = ST_READY;
      endcase
      // Outputs follow the next state so they line up with the state flops.
      tank_en_d[i] = (state_d[i] == ST_SPAWNING);
      if ((state_d[i] == ST_SPAWNING) || (state_d[i] == ST_ALIVE)) begin
        alive_cnt_d = alive_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TANK; i++) begin
        state_q[i] <= ST_READY;
        cnt_q[i]   <= '0;
`ifdef SPAWN_TIMEOUT_EN
        to_q[i]    <= '0;
`endif
      end
      rr_q        <= PTR_RST;
      tank_en_q   <= '0;
      alive_cnt_q <= '0;
`ifdef SPAWN_TIMEOUT_EN
      spawn_err_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N_TANK; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef SPAWN_TIMEOUT_EN
        to_q[i]    <= to_d[i];
`endif
      end
      rr_q        <= rr_d;
      tank_en_q   <= tank_en_d;
      alive_cnt_q <= alive_cnt_d;
`ifdef SPAWN_TIMEOUT_EN
      spawn_err_q <= spawn_err_d;
`endif
    end
  end

  assign tank_en   = tank_en_q;
  assign alive_cnt = alive_cnt_q;

`ifdef SPAWN_TIMEOUT_EN
  assign spawn_err = spawn_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (SPAWN_TIMEOUT != 0);
  assign spawn_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_enytank_spawn_ctrl.sv
`default_nettype none
// tb_enytank_spawn_ctrl: directed spawn scenarios plus randomized traffic
// checked against a rule-level reference model of the channel behaviour.
module tb_enytank_spawn_ctrl;

  localparam int N  = 4;
  localparam int RT = 3;
  localparam int MA = 2;
  localparam int TO = 4;
  localparam int CW = $clog2(N + 1);
`ifdef SPAWN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          game_en;
  logic [N-1:0]  tank_state;
  logic [N-1:0]  tank_en;
  logic [CW-1:0] alive_cnt;
  logic          spawn_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  enytank_spawn_ctrl #(
    .N_TANK       (N),
    .RESPAWN_TICKS(RT),
    .MAX_ALIVE    (MA),
    .SPAWN_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .game_en   (game_en),
    .tank_state(tank_state),
    .tank_en   (tank_en),
    .alive_cnt (alive_cnt),
    .spawn_err (spawn_err)
  );

  // Reference model: phase letter W/R/S/A, respawn ticks left, spawn age in ticks.
  logic [7:0] m_ph   [N];
  int         m_left [N];
  int         m_age  [N];
  int         m_ptr;
  logic       m_err;

  function automatic int m_busy();
    int b = 0;
    for (int i = 0; i < N; i++) if (m_ph[i] == "S" || m_ph[i] == "A") b++;
    return b;
  endfunction

  function automatic logic [N-1:0] m_en();
    logic [N-1:0] e = '0;
    for (int i = 0; i < N; i++) e[i] = (m_ph[i] == "S");
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i]   = "R";
      m_left[i] = 0;
      m_age[i]  = 0;
    end
    m_ptr = N - 1;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    int busy;
    int g;
    int idx;
    busy  = m_busy();
    g     = -1;
    m_err = 1'b0;
    if (tick && game_en && busy < MA) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && m_ph[idx] == "R" && !tank_state[idx]) g = idx;
      end
    end
    if (g >= 0) m_ptr = g;
    for (int i = 0; i < N; i++) begin
      case (m_ph[i])
        "W": begin
          if (tank_state[i]) m_ph[i] = "A";
          else if (tick && game_en) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_ph[i] = "R";
          end
        end
        "R": begin
          if (tank_state[i]) m_ph[i] = "A";
          else if (i == g) begin
            m_ph[i]  = "S";
            m_age[i] = 0;
          end
        end
        "S": begin
          if (tank_state[i]) m_ph[i] = "A";
          else if (!game_en) m_ph[i] = "R";
          else if (TIMEOUT_ON && tick) begin
            m_age[i] = m_age[i] + 1;
            if (m_age[i] == TO) begin
              m_ph[i]   = "W";
              m_left[i] = RT;
              m_err     = 1'b1;
            end
          end
        end
        "A": begin
          if (!tank_state[i]) begin
            m_ph[i]   = "W";
            m_left[i] = RT;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    tank_state = '0;
    game_en    = 1'b0;
    cyc(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    tick       = 1'b0;
    game_en    = 1'b1;
    tank_state = '0;
    model_reset();
    #2;
    repeat (2) cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tank_en: got %b want 0000", tank_en);
    end
    n_checks++;
    if (alive_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_alive_cnt: got %0d want 0", alive_cnt);
    end
    n_checks++;
    if (spawn_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_spawn_err: got %b want 0", spawn_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rr_fill();
    game_en = 1'b1;
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0001 || alive_cnt !== 3'd1) begin
      n_fail++; $display("FAIL fill_tick1: got en=%b cnt=%0d want en=0001 cnt=1", tank_en, alive_cnt);
    end
    tank_state = 4'b0001;
    cyc(1'b0);
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd1) begin
      n_fail++; $display("FAIL fill_ack0: got en=%b cnt=%0d want en=0000 cnt=1", tank_en, alive_cnt);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0010 || alive_cnt !== 3'd2) begin
      n_fail++; $display("FAIL fill_tick2: got en=%b cnt=%0d want en=0010 cnt=2", tank_en, alive_cnt);
    end
    tank_state = 4'b0011;
    cyc(1'b0);
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd2) begin
      n_fail++; $display("FAIL fill_tick3_cap: got en=%b cnt=%0d want en=0000 cnt=2", tank_en, alive_cnt);
    end
  endtask

  task automatic test_respawn_rr();
    tank_state = 4'b0010;
    cyc(1'b0);
    n_checks++;
    if (alive_cnt !== 3'd1) begin
      n_fail++; $display("FAIL kill0_cnt: got %0d want 1", alive_cnt);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0100) begin
      n_fail++; $display("FAIL rr_after_kill: got %b want 0100", tank_en);
    end
    tank_state = 4'b0110;
    cyc(1'b0);
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd2) begin
      n_fail++; $display("FAIL ack2: got en=%b cnt=%0d want en=0000 cnt=2", tank_en, alive_cnt);
    end
  endtask

  task automatic test_death_on_tick();
    tank_state = 4'b0100;
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd1) begin
      n_fail++; $display("FAIL death_tick: got en=%b cnt=%0d want en=0000 cnt=1", tank_en, alive_cnt);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b1000 || alive_cnt !== 3'd2) begin
      n_fail++; $display("FAIL death_next_tick: got en=%b cnt=%0d want en=1000 cnt=2", tank_en, alive_cnt);
    end
  endtask

  task automatic test_game_en_drop();
    do_reset();
    tank_state = 4'b0111;
    cyc(1'b0);
    n_checks++;
    if (alive_cnt !== 3'd3) begin
      n_fail++; $display("FAIL ext_spawn_cnt: got %0d want 3", alive_cnt);
    end
    tank_state = 4'b0100;
    cyc(1'b0);
    game_en = 1'b1;
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b1000 || alive_cnt !== 3'd2) begin
      n_fail++; $display("FAIL grant3: got en=%b cnt=%0d want en=1000 cnt=2", tank_en, alive_cnt);
    end
    game_en = 1'b0;
    cyc(1'b0);
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd1) begin
      n_fail++; $display("FAIL game_off: got en=%b cnt=%0d want en=0000 cnt=1", tank_en, alive_cnt);
    end
    game_en = 1'b1;
    cyc(1'b0);
    n_checks++;
    if (tank_en !== 4'b0000) begin
      n_fail++; $display("FAIL game_on_no_tick: got %b want 0000", tank_en);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b1000) begin
      n_fail++; $display("FAIL regrant3: got %b want 1000", tank_en);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tank_en !== 4'b0000 || alive_cnt !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: got en=%b cnt=%0d want en=0000 cnt=0", tank_en, alive_cnt);
    end
    model_reset();
    tank_state = '0;
    cyc(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    game_en = 1'b1;
    cyc(1'b1);
    tank_state = 4'b1110;
    cyc(1'b0);
    repeat (3) cyc(1'b1);
    n_checks++;
    if (tank_en[0] !== 1'b1 || spawn_err !== 1'b0) begin
      n_fail++; $display("FAIL pre_timeout: got en0=%b err=%b want en0=1 err=0", tank_en[0], spawn_err);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en[0] !== 1'b0 || spawn_err !== 1'b1 || alive_cnt !== 3'd3) begin
      n_fail++; $display("FAIL timeout: got en0=%b err=%b cnt=%0d want en0=0 err=1 cnt=3", tank_en[0], spawn_err, alive_cnt);
    end
    cyc(1'b0);
    n_checks++;
    if (spawn_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: got %b want 0", spawn_err);
    end
    cyc(1'b1);
    tank_state = 4'b0000;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0000) begin
      n_fail++; $display("FAIL early_regrant: got %b want 0000", tank_en);
    end
    cyc(1'b1);
    n_checks++;
    if (tank_en !== 4'b0001) begin
      n_fail++; $display("FAIL regrant_after_timeout: got %b want 0001", tank_en);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ts;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      ts = '0;
      for (int i = 0; i < N; i++) begin
        case (m_ph[i])
          "S":     ts[i] = ($urandom_range(0, 99) < 40);
          "A":     ts[i] = ($urandom_range(0, 99) < 90);
          default: ts[i] = ($urandom_range(0, 99) < 2);
        endcase
      end
      tank_state = ts;
      game_en    = ($urandom_range(0, 99) < 90);
      cyc($urandom_range(0, 2) == 0);
      n_checks++;
      if (tank_en !== m_en()) begin
        n_fail++; $display("FAIL rand_tank_en c=%0d: got %b want %b", c, tank_en, m_en());
      end
      n_checks++;
      if (alive_cnt !== CW'(m_busy())) begin
        n_fail++; $display("FAIL rand_alive_cnt c=%0d: got %0d want %0d", c, alive_cnt, m_busy());
      end
      n_checks++;
      if (spawn_err !== m_err) begin
        n_fail++; $display("FAIL rand_spawn_err c=%0d: got %b want %b", c, spawn_err, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_fill();
    test_respawn_rr();
    test_death_on_tick();
    test_game_en_drop();
    test_async_reset();
    if (TIMEOUT_ON) test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enytank_spawn_ctrl.md
ENYTANK_SPAWN_CTRL -- requirements
Module: enytank_spawn_ctrl

Interface
REQ-001 The module SHALL have parameter N_TANK, default 4, meaning number of enemy-tank channels (1..8).
REQ-002 The module SHALL have parameter RESPAWN_TICKS, default 8, meaning ticks a dead channel waits before it is spawn-eligible (1..255).
REQ-003 The module SHALL have parameter MAX_ALIVE, default 3, meaning cap on channels simultaneously spawning or alive (1..N_TANK).
REQ-004 The module SHALL have parameter SPAWN_TIMEOUT, default 4, meaning ticks allowed for spawn acknowledge (1..255), used only when SPAWN_TIMEOUT_EN is defined.
REQ-005 The module SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port tick, input, 1 bit: one-clk-wide game-rate strobe, synchronous to clk.
REQ-008 The module SHALL have port game_en, input, 1 bit: spawning permitted when high.
REQ-009 The module SHALL have port tank_state, input, N_TANK bits: per-channel alive flag from the tank logic (1 = alive).
REQ-010 The module SHALL have port tank_en, output, N_TANK bits: per-channel spawn request, registered.
REQ-011 The module SHALL have port alive_cnt, output, $clog2(N_TANK+1) bits: count of channels in SPAWNING or ALIVE, registered.
REQ-012 The module SHALL have port spawn_err, output, 1 bit: one-clk pulse on spawn timeout.

Function
REQ-013 Each channel SHALL implement states WAIT, READY, SPAWNING and ALIVE, with an 8-bit countdown counter.
REQ-014 WAIT: on tick with counter>1 decrement; on tick with counter==1 go READY with counter 0.
REQ-015 READY -> SPAWNING only when granted; tank_en[i] SHALL be 1 exactly while channel i is in SPAWNING.
REQ-016 Grant SHALL be evaluated only on a tick cycle with game_en=1 and alive_cnt<MAX_ALIVE, granting at most one channel per tick.
REQ-017 Grant SHALL be round-robin: search starts at (last granted index+1) mod N_TANK; the pointer updates only on a grant.
REQ-018 SPAWNING -> ALIVE on any clk with tank_state[i]=1 (ack; level-sampled, not tick-gated).
REQ-019 ALIVE -> WAIT on any clk with tank_state[i]=0, loading counter=RESPAWN_TICKS; a coincident tick SHALL NOT decrement in that cycle.
REQ-020 alive_cnt SHALL equal the number of channels in SPAWNING or ALIVE, updated the clk after any state change, and SHALL never exceed MAX_ALIVE through a grant.
REQ-021 A grant decision SHALL use the alive_cnt value registered before that clk; a same-cycle death SHALL NOT free a slot until the next tick.
REQ-022 game_en=0 SHALL return SPAWNING channels to READY, freeze WAIT counters, and block grants; ALIVE channels SHALL still track deaths to WAIT.
REQ-023 When tank_state[i]=1 while channel i is in WAIT or READY, the channel SHALL go to ALIVE (external spawn is tolerated).

Reset
REQ-024 While rst_n=0, all channels SHALL be in READY with counter 0, tank_en=0, alive_cnt=0, spawn_err=0, and the round-robin pointer SHALL be N_TANK-1 so that channel 0 is searched first.
REQ-025 Reset SHALL act immediately regardless of clk; asserting it mid-spawn SHALL drop tank_en asynchronously.
REQ-026 The first grant after reset release SHALL occur on the first qualifying tick.

Configuration
REQ-027 When macro SPAWN_TIMEOUT_EN is defined, each SPAWNING channel SHALL count ticks; when SPAWN_TIMEOUT ticks pass without ack, the channel SHALL go to WAIT with counter=RESPAWN_TICKS, and spawn_err SHALL pulse for 1 clk.
REQ-028 When macro SPAWN_TIMEOUT_EN is undefined, SPAWNING SHALL persist until ack or game_en=0, spawn_err SHALL be tied to 0, and no timeout counter SHALL be synthesised.

Verification
All scenarios use N_TANK=4, RESPAWN_TICKS=3, MAX_ALIVE=2, SPAWN_TIMEOUT=4.
REQ-029 Reset release, game_en=1, instant acks: tick1 -> tank_en=0001; tick2 -> tank_en=0010; tick3 -> no grant; alive_cnt=2.
REQ-030 Kill channel 0 after it is alive: WAIT for 3 ticks -> READY; the next tick grants channel 2 (round-robin order), not channel 0.
REQ-031 Death of channel 1 coincident with a tick while alive_cnt=2: no grant that tick; grant on the following tick; alive_cnt drops 2 -> 1 then rises 1 -> 2.
REQ-032 game_en dropped while channel 3 is in SPAWNING: tank_en[3]=0 the next clk and channel 3 returns to READY; after game_en rises, the next tick re-grants it.
REQ-033 With SPAWN_TIMEOUT_EN defined and channel 0 never acked: after 4 ticks, tank_en[0]=0 and spawn_err=1 for 1 clk, alive_cnt is decremented, and the channel is eligible again after 3 more ticks.
REQ-034 rst_n asserted asynchronously mid-spawn: tank_en=0000 and alive_cnt=0 before the next clk edge.
